// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and a valid/ack handshake.
//   Columns are strobed active-low one at a time for SCAN_TICKS clocks each.
//   The synchronized rows are sampled at the end of each column dwell. After
//   column 3 the full scan is classified as NONE, SINGLE or MULTI, and a
//   debounce FSM steps once per scan.
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   row[3:0]    - keypad rows, active-low, asynchronous to clk
//   col[3:0]    - column strobe, active-low one-hot
//   key_code    - accepted key {row_index, col_index}
//   key_valid   - new key_code pending; held until key_ack
//   key_ack     - consumer acknowledge (ignored while key_valid is 0)
//   key_down    - debounced key-held level
//   overrun     - sticky; a key was accepted while key_valid was still pending
// Build option: define KEYPAD_AUTOREPEAT_EN to re-accept the held key every
//   REPEAT_SCANS scans spent in HELD.
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS     = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int unsigned DWELL_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    logic [3:0]         row_meta_q, row_sync_q;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [3:0]         col_q, col_d;
    logic [2:0][3:0]    snap_q, snap_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d, db_next;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_down_q, key_down_d;
    logic               overrun_q, overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_SCANS + 1);
    logic [RPT_W-1:0]   rep_cnt_q, rep_cnt_d, rep_next;
`endif

    logic        tick, scan_done, accept;
    logic [15:0] low_map;
    logic [4:0]  n_low;
    logic [3:0]  hit_code;
    logic        res_none, res_single;

    // Column dwell timing and per-column row snapshots
    always_comb begin
        tick      = (dwell_q == DWELL_W'(SCAN_TICKS - 1));
        scan_done = tick && (col_idx_q == 2'd3);
        dwell_d   = tick ? '0 : dwell_q + DWELL_W'(1);
        col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = ~(4'b0001 << col_idx_d);
        snap_d    = snap_q;
        for (int c = 0; c < 3; c++) begin
            if (tick && (col_idx_q == 2'(c))) snap_d[c] = row_sync_q;
        end
    end

    // Scan classification; column 3 is taken straight from the synchronizer
    // on the same edge it would be snapshotted. Bit index is col*4 + row.
    always_comb begin
        low_map  = ~{row_sync_q, snap_q[2], snap_q[1], snap_q[0]};
        n_low    = '0;
        hit_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (low_map[i]) begin
                n_low    = n_low + 5'd1;
                hit_code = {2'(i % 4), 2'(i / 4)};
            end
        end
        res_none   = (n_low == 5'd0);
        res_single = (n_low == 5'd1);
    end

    // Debounce FSM and output handshake
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        db_next    = db_cnt_q + CNT_W'(1);
        cand_d     = cand_q;
        key_down_d = key_down_q;
        accept     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_next   = rep_cnt_q + RPT_W'(1);
`endif
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_d = hit_code;
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d  = HELD;
                            accept   = 1'b1;
                            db_cnt_d = '0;
                        end else begin
                            state_d  = PRESS_DB;
                            db_cnt_d = CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (res_single && (hit_code == cand_q)) begin
                        if (db_next == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d  = HELD;
                            accept   = 1'b1;
                            db_cnt_d = '0;
                        end else begin
                            db_cnt_d = db_next;
                        end
                    end else begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_d    = IDLE;
                            key_down_d = 1'b0;
                            db_cnt_d   = '0;
                        end else begin
                            state_d  = RELEASE_DB;
                            db_cnt_d = CNT_W'(1);
                        end
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_next == RPT_W'(REPEAT_SCANS)) begin
                        accept    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_next;
                    end
`endif
                end
                RELEASE_DB: begin
                    if (res_none) begin
                        if (db_next == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d    = IDLE;
                            key_down_d = 1'b0;
                            db_cnt_d   = '0;
                        end else begin
                            db_cnt_d = db_next;
                        end
                    end else begin
                        state_d  = HELD;
                        db_cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat interval restarts on a fresh press and clears once released
        if (state_d != HELD && state_d != RELEASE_DB) rep_cnt_d = '0;
        if (accept && state_q != HELD) rep_cnt_d = '0;
`endif
        if (accept) key_down_d = 1'b1;

        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (accept) begin
            key_code_d  = cand_d;
            key_valid_d = 1'b1;
            if (key_valid_q && !key_ack) overrun_d = 1'b1;
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            dwell_q     <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            snap_q      <= '0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            dwell_q     <= dwell_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner.
//   A keypad model drives rows from the column strobe and a 16-bit pressed-key
//   mask (bit index = row*4 + col = key code). Each step holds one mask for a
//   whole scan. Directed vectors come from a table; a randomized phase is
//   checked against a scan-level reference model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_TICKS = 4;
    localparam int unsigned DB         = 2;
    localparam int unsigned REP        = 3;
    localparam int          SCAN_CYC   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack = 1'b0;
    logic        key_down;
    logic        overrun;
    logic [15:0] mask = 16'h0000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS    (SCAN_TICKS),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .key_down (key_down),
        .overrun  (overrun)
    );

    // Matrix: a pressed key pulls its row low while its column is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mask    = 16'h0000;
        key_ack = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One full scan with mask m; am: 0 no ack, 1 ack mid-scan, 2 ack on the scan-end edge
    task automatic do_scan(input logic [15:0] m, input int am);
        logic [3:0] one;
        logic [3:0] exp_col;
        mask = m;
        for (int e = 1; e <= SCAN_CYC; e++) begin
            key_ack = ((am == 1) && (e == 8)) || ((am == 2) && (e == SCAN_CYC));
            @(posedge clk); #1;
            key_ack = 1'b0;
            if (e % 4 == 0) begin
                one     = 4'b0001;
                exp_col = ~(one << ((e / 4) % 4));
                chk("col_strobe", col, exp_col);
            end
        end
    endtask

    // Scan-level reference model
    bit         m_valid, m_down, m_ov;
    logic [3:0] m_code, m_cand;
    int         m_run, m_none, m_held;

    task automatic model_reset();
        m_valid = 0; m_down = 0; m_ov = 0;
        m_code = 4'h0; m_cand = 4'h0;
        m_run = 0; m_none = 0; m_held = 0;
    endtask

    task automatic model_scan(input logic [15:0] m, input int am);
        int n;
        int k;
        bit acc;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        acc = 0;
        if (am == 1) m_valid = 0;
        if (!m_down) begin
            if (n == 1 && (m_run == 0 || 4'(k) == m_cand)) begin
                m_cand = 4'(k);
                m_run++;
                if (m_run == int'(DB)) begin
                    acc = 1; m_down = 1; m_run = 0; m_held = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) begin
                m_none++;
                if (m_none == int'(DB)) begin
                    m_down = 0; m_none = 0;
                end
            end else begin
                if (m_none == 0) begin
                    m_held++;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (m_held == int'(REP)) begin
                        acc = 1; m_held = 0;
                    end
`endif
                end
                m_none = 0;
            end
        end
        if (acc) begin
            if (m_valid && am != 2) m_ov = 1;
            m_valid = 1;
            m_code  = m_cand;
        end else if (m_valid && am == 2) begin
            m_valid = 0;
        end
    endtask

    typedef struct {
        bit          rst;
        logic [15:0] m;
        int          am;
        bit          v;
        bit          d;
        logic [3:0]  c;
        bit          ov;
    } vec_t;

    vec_t tbl [39];
    int   accepts;
    int   exp_accepts;
    logic [15:0] rm;
    logic [15:0] one16;

    initial begin
        // rst, mask, ack, valid, down, code, overrun (observed at scan end)
        tbl[0]  = '{0, 16'h0200, 0, 0, 0, 4'h0, 0};
        tbl[1]  = '{0, 16'h0200, 0, 1, 1, 4'h9, 0};
        tbl[2]  = '{0, 16'h0000, 2, 0, 1, 4'h9, 0};
        tbl[3]  = '{0, 16'h0000, 0, 0, 0, 4'h9, 0};
        tbl[4]  = '{0, 16'h0200, 0, 0, 0, 4'h9, 0};
        tbl[5]  = '{0, 16'h0000, 0, 0, 0, 4'h9, 0};
        tbl[6]  = '{0, 16'h0000, 0, 0, 0, 4'h9, 0};
        tbl[7]  = '{0, 16'h0021, 0, 0, 0, 4'h9, 0};
        tbl[8]  = '{0, 16'h0021, 0, 0, 0, 4'h9, 0};
        tbl[9]  = '{0, 16'h0021, 0, 0, 0, 4'h9, 0};
        tbl[10] = '{0, 16'h0000, 0, 0, 0, 4'h9, 0};
        tbl[11] = '{0, 16'h0008, 0, 0, 0, 4'h9, 0};
        tbl[12] = '{0, 16'h0008, 0, 1, 1, 4'h3, 0};
        tbl[13] = '{0, 16'h0000, 0, 1, 1, 4'h3, 0};
        tbl[14] = '{0, 16'h0000, 0, 1, 0, 4'h3, 0};
        tbl[15] = '{0, 16'h4000, 0, 1, 0, 4'h3, 0};
        tbl[16] = '{0, 16'h4000, 0, 1, 1, 4'hE, 1};
        tbl[17] = '{0, 16'h0000, 1, 0, 1, 4'hE, 1};
        tbl[18] = '{0, 16'h0000, 0, 0, 0, 4'hE, 1};
        tbl[19] = '{0, 16'h0200, 0, 0, 0, 4'hE, 1};
        tbl[20] = '{1, 16'h0200, 0, 0, 0, 4'h0, 0};
        tbl[21] = '{0, 16'h0200, 0, 1, 1, 4'h9, 0};
        tbl[22] = '{1, 16'h0000, 0, 0, 0, 4'h0, 0};
        tbl[23] = '{0, 16'h0200, 0, 0, 0, 4'h0, 0};
        tbl[24] = '{0, 16'h0200, 0, 1, 1, 4'h9, 0};
        tbl[25] = '{0, 16'h0000, 0, 1, 1, 4'h9, 0};
        tbl[26] = '{0, 16'h0000, 0, 1, 0, 4'h9, 0};
        tbl[27] = '{0, 16'h4000, 0, 1, 0, 4'h9, 0};
        tbl[28] = '{0, 16'h4000, 2, 1, 1, 4'hE, 0};
        tbl[29] = '{0, 16'h0000, 2, 0, 1, 4'hE, 0};
        tbl[30] = '{0, 16'h0000, 0, 0, 0, 4'hE, 0};
        tbl[31] = '{0, 16'h0200, 0, 0, 0, 4'hE, 0};
        tbl[32] = '{0, 16'h0008, 0, 0, 0, 4'hE, 0};
        tbl[33] = '{0, 16'h0008, 0, 0, 0, 4'hE, 0};
        tbl[34] = '{0, 16'h0008, 0, 1, 1, 4'h3, 0};
        tbl[35] = '{0, 16'h0000, 0, 1, 1, 4'h3, 0};
        tbl[36] = '{0, 16'h0008, 0, 1, 1, 4'h3, 0};
        tbl[37] = '{0, 16'h0000, 0, 1, 1, 4'h3, 0};
        tbl[38] = '{0, 16'h0000, 0, 1, 0, 4'h3, 0};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_col", col, 4'b1110);
        chk("reset_valid", {3'b0, key_valid}, 4'h0);
        chk("reset_down", {3'b0, key_down}, 4'h0);
        chk("reset_code", key_code, 4'h0);
        chk("reset_overrun", {3'b0, overrun}, 4'h0);

        // Directed vectors
        for (int i = 0; i < 39; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                chk("rst_col", col, 4'b1110);
                chk("rst_valid", {3'b0, key_valid}, 4'h0);
                chk("rst_down", {3'b0, key_down}, 4'h0);
                chk("rst_code", key_code, 4'h0);
                chk("rst_overrun", {3'b0, overrun}, 4'h0);
            end
            do_scan(tbl[i].m, tbl[i].am);
            chk($sformatf("vec%0d_valid", i), {3'b0, key_valid}, {3'b0, tbl[i].v});
            chk($sformatf("vec%0d_down", i), {3'b0, key_down}, {3'b0, tbl[i].d});
            chk($sformatf("vec%0d_code", i), key_code, tbl[i].c);
            chk($sformatf("vec%0d_overrun", i), {3'b0, overrun}, {3'b0, tbl[i].ov});
        end

        // Long hold with an ack every scan: count accepts
        do_reset();
        accepts = 0;
        for (int s = 0; s < 9; s++) begin
            do_scan(16'h0400, 2);
            if (key_valid) accepts++;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_accepts = 3;
`else
        exp_accepts = 1;
`endif
        chk("hold_accepts", 4'(accepts), 4'(exp_accepts));
        chk("hold_down", {3'b0, key_down}, 4'h1);
        chk("hold_code", key_code, 4'hA);
        chk("hold_overrun", {3'b0, overrun}, 4'h0);

        // Randomized scans against the reference model
        do_reset();
        model_reset();
        rm = 16'h0000;
        one16 = 16'h0001;
        for (int s = 0; s < 60; s++) begin
            int r;
            int am;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) begin
                if (r < 4) rm = 16'h0000;
                else if (r < 8) rm = one16 << (5 * int'($urandom_range(0, 2)));
                else rm = (one16 << int'($urandom_range(0, 7))) | (one16 << int'($urandom_range(8, 15)));
            end
            am = int'($urandom_range(0, 2));
            model_scan(rm, am);
            do_scan(rm, am);
            chk($sformatf("rnd%0d_valid", s), {3'b0, key_valid}, {3'b0, m_valid});
            chk($sformatf("rnd%0d_down", s), {3'b0, key_down}, {3'b0, m_down});
            chk($sformatf("rnd%0d_code", s), key_code, m_code);
            chk($sformatf("rnd%0d_overrun", s), {3'b0, overrun}, {3'b0, m_ov});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 100000, clk cycles each column is strobed (1 ms at 100 MHz); legal range 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans required to accept a press or a release; legal range 1 to 15.
REQ-003 SHALL have parameter REPEAT_SCANS, default 250, full scans between auto-repeat events; used only when KEYPAD_AUTOREPEAT_EN is defined.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 SHALL have port col  output  4  column strobe, active-low one-hot.
REQ-008 SHALL have port key_code  output  4  accepted key, encoded as {row_index[1:0], col_index[1:0]}.
REQ-009 SHALL have port key_valid  output  1  new key_code available; held until acknowledged.
REQ-010 SHALL have port key_ack  input  1  consumer acknowledge, sampled only while key_valid is 1.
REQ-011 SHALL have port key_down  output  1  level, 1 while a debounced key is held.
REQ-012 SHALL have port overrun  output  1  sticky, a press was accepted while key_valid was pending.

Function
REQ-013 SHALL pass row through a 2-flop synchronizer before any use.
REQ-014 SHALL run dwell counter 0..SCAN_TICKS-1; at terminal count, SHALL snapshot synchronized row for the current column and advance col 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-015 SHALL complete one scan after the column-3 snapshot; the scan result is NONE (no row low), SINGLE(code) (exactly one row low in exactly one column) or MULTI (anything else).
REQ-016 SHALL implement FSM IDLE, PRESS_DB, HELD, RELEASE_DB, evaluated once per completed scan.
REQ-017 IDLE: SINGLE(c) -> PRESS_DB with candidate=c, count=1; NONE or MULTI -> stay IDLE.
REQ-018 PRESS_DB: SINGLE(candidate) increments count; when count reaches DEBOUNCE_SCANS -> HELD and accept; any other result -> IDLE.
REQ-019 Accept: key_code<=candidate, key_valid<=1, key_down<=1 on the same clk as the FSM transition.
REQ-020 HELD: NONE -> RELEASE_DB, count=1; SINGLE or MULTI -> stay HELD.
REQ-021 RELEASE_DB: NONE increments count; count reaching DEBOUNCE_SCANS -> IDLE with key_down<=0; SINGLE or MULTI -> HELD.
REQ-022 DEBOUNCE_SCANS=1 SHALL accept a press or release on the first qualifying scan.
REQ-023 key_valid SHALL clear on the cycle after key_ack=1 with key_valid=1; key_ack while key_valid=0 SHALL be ignored.
REQ-024 An accept while key_valid=1 and key_ack=0 SHALL overwrite key_code, keep key_valid=1 and set overrun.
REQ-025 An accept coinciding with key_ack=1 SHALL load the new key_code, keep key_valid=1 and leave overrun unchanged.
REQ-026 overrun SHALL clear only on reset.

Reset
REQ-027 On reset=1 at a clk edge: col=1110, dwell count=0, scan snapshots=0, FSM=IDLE, debounce count=0, key_code=0, key_valid=0, key_down=0, overrun=0, synchronizer=1111.
REQ-028 Reset mid-debounce or mid-handshake SHALL discard the pending candidate and pending key_valid with no output glitch beyond the reset values.

Configuration
REQ-029 With KEYPAD_AUTOREPEAT_EN defined, the block SHALL re-issue an accept (REQ-019, REQ-024, REQ-025 apply) every REPEAT_SCANS completed scans spent in HELD, counting from entry to HELD; the counter SHALL reset on leaving HELD and SHALL keep counting through a RELEASE_DB -> HELD bounce.
REQ-030 Without KEYPAD_AUTOREPEAT_EN, the block SHALL issue exactly one accept per press, and REPEAT_SCANS SHALL be unused.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3)
REQ-031 Hold row=1011 during col=1101 for 2 scans -> key_valid rises with key_code=4'b1001 at the end of scan 2; key_down=1.
REQ-032 Press for 1 scan only, then release -> key_valid and key_down stay 0.
REQ-033 Two keys in different columns for 3 scans -> no accept; then release and press a single key for 2 scans -> accept.
REQ-034 Accept key A with no ack, then release and accept key B -> key_code=B, key_valid=1, overrun=1; with ack on the same clk as B's accept -> overrun=0.
REQ-035 Assert reset while in PRESS_DB and while key_valid=1 -> all outputs at reset values next cycle, col=1110.
REQ-036 With KEYPAD_AUTOREPEAT_EN and a key held with ack given each time -> accepts after 2 scans, then at 3-scan intervals; without the macro -> exactly one accept.
